// File: rtl/div_seq_pkg.sv
// Shared types for the multi-cycle DIV/DIVU sequencer.
package div_seq_pkg;

  localparam int unsigned DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on the {partial remainder, quotient} register.
module div_step
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic [2*DATA_W:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [2*DATA_W:0] dividend_next
);

  logic [DATA_W:0] trial;

  always_comb begin
    trial = dividend[2*DATA_W:DATA_W] - {1'b0, divisor};
    // A set MSB means the partial remainder is below the divisor: restore by shifting only.
    if (trial[DATA_W]) begin
      dividend_next = {dividend[2*DATA_W-1:0], 1'b0};
    end else begin
      dividend_next = {trial[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// DIV/DIVU sequencer: magnitude restoring divide over DATA_W steps, sign fixed up on exit.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  div_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2*DATA_W:0]   dividend, dividend_nxt, dividend_step;
  logic [DATA_W-1:0]   divisor, divisor_nxt;
  logic                is_signed, is_signed_nxt;
  logic                sgn1, sgn1_nxt, sgn2, sgn2_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic                ready_nxt;

  logic                neg1, neg2;
  logic [DATA_W-1:0]   abs1, abs2, quo, rem;

  div_step #(.DATA_W(DATA_W)) u_step (
    .dividend      (dividend),
    .divisor       (divisor),
    .dividend_next (dividend_step)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    dividend_nxt  = dividend;
    divisor_nxt   = divisor;
    is_signed_nxt = is_signed;
    sgn1_nxt      = sgn1;
    sgn2_nxt      = sgn2;
    result_nxt    = result_o;
    ready_nxt     = ready_o;

    neg1 = signed_div_i & opdata1_i[DATA_W-1];
    neg2 = signed_div_i & opdata2_i[DATA_W-1];
    abs1 = neg1 ? -opdata1_i : opdata1_i;
    abs2 = neg2 ? -opdata2_i : opdata2_i;

    quo = dividend[DATA_W-1:0];
    rem = dividend[2*DATA_W:DATA_W+1];
    if (is_signed & (sgn1 ^ sgn2)) quo = -dividend[DATA_W-1:0];
    if (is_signed & sgn1)          rem = -dividend[2*DATA_W:DATA_W+1];

    case (state)
      DIV_FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = DIV_BYZERO;
          end else begin
            state_nxt     = DIV_ON;
            dividend_nxt  = {{DATA_W{1'b0}}, abs1, 1'b0};
            divisor_nxt   = abs2;
            is_signed_nxt = signed_div_i;
            sgn1_nxt      = opdata1_i[DATA_W-1];
            sgn2_nxt      = opdata2_i[DATA_W-1];
            cnt_nxt       = '0;
          end
        end
      end
      DIV_BYZERO: begin
        state_nxt    = DIV_END;
        dividend_nxt = '0;
        result_nxt   = '0;
        ready_nxt    = 1'b1;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_nxt  = DIV_FREE;
          cnt_nxt    = '0;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end else if (cnt != CNT_W'(DATA_W)) begin
          dividend_nxt = dividend_step;
          cnt_nxt      = cnt + 1'b1;
        end else begin
          state_nxt  = DIV_END;
          result_nxt = {rem, quo};
          ready_nxt  = 1'b1;
          cnt_nxt    = '0;
        end
      end
      DIV_END: begin
        if (!start_i) begin
          state_nxt  = DIV_FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end
      default: state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_FREE;
      cnt       <= '0;
      dividend  <= '0;
      divisor   <= '0;
      is_signed <= 1'b0;
      sgn1      <= 1'b0;
      sgn2      <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dividend  <= dividend_nxt;
      divisor   <= divisor_nxt;
      is_signed <= is_signed_nxt;
      sgn1      <= sgn1_nxt;
      sgn2      <= sgn2_nxt;
      result_o  <= result_nxt;
      ready_o   <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver queues reference results, monitor checks on ready_o.
module tb_div_seq;

  localparam int unsigned W      = 32;
  localparam int unsigned ON_LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          signed_div = 1'b0;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  logic          start = 1'b0;
  logic          annul = 1'b0;
  logic [2*W-1:0] result;
  logic          ready;

  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic [2*W-1:0] res;
    int unsigned    e0;
    bit             byzero;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes dividend sign).
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
  endtask

  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int unsigned hold;
    drive_op(sgn, a, b);
    e.res    = ref_div(sgn, a, b);
    e.e0     = cyc + 1;
    e.byzero = (b == 32'd0);
    sb_q.push_back(e);
    // Operands changing after the start edge must not disturb the divide.
    @(negedge clk);
    op1        = $urandom;
    op2        = $urandom;
    signed_div = 1'($urandom);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (ready) break;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: ready_o=%b after 60 cycles, required 1 (a=%h b=%h)", ready, a, b);
      sb_q.delete();
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      @(posedge clk); #1;
      check("ready_hold", 64'(ready), 64'd1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", 64'(ready), 64'd0);
    check("drop_result", result, 64'd0);
  endtask

  initial begin : monitor
    logic           prev;
    logic [2*W-1:0] held;
    exp_t           e;
    int unsigned    lat;
    prev = 1'b0;
    held = '0;
    forever begin
      @(posedge clk); #1;
      if (ready && !prev) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ready: ready_o=1 with no divide outstanding, result_o=%h", result);
        end else begin
          e = sb_q.pop_front();
          check("result", result, e.res);
          lat = cyc - e.e0;
          if (e.byzero) begin
            vectors++;
            if (lat < 1 || lat > 2) begin
              miscompares++;
              $display("FAIL byzero_latency: got %0d edges, required 1..2", lat);
            end
          end else begin
            check("latency", 64'(lat), 64'(ON_LAT));
          end
        end
        held = result;
      end else if (ready && prev) begin
        check("held_result", result, held);
      end
      prev = ready;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [31:0] a, b;
    bit          sgn;
    int unsigned sel;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7);
    do_div(1'b1, -32'sd7, 32'd2);
    do_div(1'b1, 32'd7, -32'sd2);
    do_div(1'b0, 32'd5, 32'd0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1);

    // Flush mid-divide: annul sampled while the step counter reads 10.
    drive_op(1'b0, 32'd9, 32'd3);
    repeat (11) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("annul_no_ready", 64'(ready), 64'd0);
    do_div(1'b0, 32'd9, 32'd3);

    // Synchronous reset while the step counter reads 20.
    drive_op(1'b1, 32'h1234_5678, 32'h0000_0321);
    repeat (21) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midop_reset_ready", 64'(ready), 64'd0);
    check("midop_reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_idle", 64'(ready), 64'd0);

    for (int n = 0; n < 24; n++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_div(sgn, a, b);
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
